// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one main-memory port between I-cache and D-cache
// Optional round-robin tie-break enabled by defining MEM_ARB_RR_EN (fixed D-cache priority otherwise).
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_req_valid,
  input  logic              dc_req_wr,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_req_valid,
  output logic              mem_req_wr,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GNT_IC  = 3'd1,
    GNT_DC  = 3'd2,
    RESP_IC = 3'd3,
    RESP_DC = 3'd4
  } state_t;

  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;

  localparam int              WD_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

  state_t          state;
  logic            last_grant;
  logic [WD_W-1:0] wdog;
  logic            pick_dc;
  logic            in_gnt;

  assign in_gnt = (state == GNT_IC) || (state == GNT_DC);

`ifdef MEM_ARB_RR_EN
  // On a tie, hand the port to whichever side did not complete last.
  always_comb begin
    pick_dc = dc_req_valid;
    if (ic_req_valid && dc_req_valid) begin
      pick_dc = (last_grant == GRANT_IC);
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    pick_dc = dc_req_valid;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= GRANT_IC;
      wdog          <= '0;
      ic_rdata      <= '0;
      ic_ready      <= 1'b0;
      dc_rdata      <= '0;
      dc_ready      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_wr    <= 1'b0;
      mem_req_addr  <= '0;
      mem_wr_data   <= '0;
      arb_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ic_req_valid || dc_req_valid) begin
            mem_req_valid <= 1'b1;
            wdog          <= '0;
            if (pick_dc) begin
              state        <= GNT_DC;
              mem_req_wr   <= dc_req_wr;
              mem_req_addr <= dc_req_addr;
              mem_wr_data  <= dc_wdata;
            end else begin
              state        <= GNT_IC;
              mem_req_wr   <= 1'b0;
              mem_req_addr <= ic_req_addr;
              mem_wr_data  <= '0;
            end
          end
        end
        GNT_IC: begin
          if (mem_ready) begin
            ic_rdata      <= mem_rdata;
            ic_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            last_grant    <= GRANT_IC;
            state         <= RESP_IC;
          end
        end
        GNT_DC: begin
          if (mem_ready) begin
            dc_rdata      <= mem_rdata;
            dc_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            last_grant    <= GRANT_DC;
            state         <= RESP_DC;
          end
        end
        // Requests are not sampled here so a still-high valid cannot re-grant.
        RESP_IC: begin
          ic_ready <= 1'b0;
          state    <= IDLE;
        end
        RESP_DC: begin
          dc_ready <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Watchdog saturates at the limit; the flag stays set until reset.
      if (in_gnt && !mem_ready && (TIMEOUT_CYC != 0) && (wdog != WD_LIMIT)) begin
        wdog <= wdog + WD_W'(1);
        if (wdog == WD_LIMIT - WD_W'(1)) begin
          arb_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_req_valid = 1'b0;
  logic [31:0] ic_req_addr = '0;
  logic [31:0] ic_rdata;
  logic        ic_ready;
  logic        dc_req_valid = 1'b0;
  logic        dc_req_wr = 1'b0;
  logic [31:0] dc_req_addr = '0;
  logic [31:0] dc_wdata = '0;
  logic [31:0] dc_rdata;
  logic        dc_ready;
  logic        mem_req_valid;
  logic        mem_req_wr;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        arb_timeout;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
    .dc_req_valid(dc_req_valid), .dc_req_wr(dc_req_wr), .dc_req_addr(dc_req_addr),
    .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .mem_req_valid(mem_req_valid), .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
    .mem_wr_data(mem_wr_data), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
  } mreq_t;

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } resp_t;

  mreq_t mq[$];
  resp_t icq[$];
  resp_t dcq[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a == 32'h0000_0040) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  // Memory model: answers after mem_delay cycles of a held request unless mem_hold is set.
  int   mem_delay = 4;
  int   mem_cnt   = 0;
  logic mem_hold  = 1'b0;

  always @(negedge clk) begin
    if (mem_req_valid && !mem_ready && !mem_hold) begin
      if (mem_cnt + 1 >= mem_delay) begin
        mem_ready = 1'b1;
        mem_rdata = rd_val(mem_req_addr);
        mem_cnt   = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (!mem_req_valid) mem_cnt = 0;
    end
  end

  // Monitor: pops expectations whenever the DUT starts a memory request or pulses ready.
  logic  prev_v = 1'b0, prev_icr = 1'b0, prev_dcr = 1'b0;
  mreq_t cap;

  always @(negedge clk) begin
    if (mem_req_valid && !prev_v) begin
      chk("mem_req_expected", 32'(mq.size() != 0), 32'd1);
      if (mq.size() != 0) begin
        cap = mq.pop_front();
        chk("mem_req_addr", mem_req_addr, cap.addr);
        chk("mem_req_wr", 32'(mem_req_wr), 32'(cap.wr));
        chk("mem_wr_data", mem_wr_data, cap.wd);
      end
    end else if (mem_req_valid) begin
      chk("mem_addr_stable", mem_req_addr, cap.addr);
      chk("mem_data_stable", mem_wr_data, cap.wd);
    end
    prev_v = mem_req_valid;

    if (ic_ready) begin
      chk("ic_ready_pulse", 32'(prev_icr), 32'd0);
      chk("ic_ready_expected", 32'(icq.size() != 0), 32'd1);
      if (icq.size() != 0) begin
        resp_t r;
        r = icq.pop_front();
        if (r.chk) chk("ic_rdata", ic_rdata, r.data);
      end
    end
    prev_icr = ic_ready;

    if (dc_ready) begin
      chk("dc_ready_pulse", 32'(prev_dcr), 32'd0);
      chk("dc_ready_expected", 32'(dcq.size() != 0), 32'd1);
      if (dcq.size() != 0) begin
        resp_t r;
        r = dcq.pop_front();
        if (r.chk) chk("dc_rdata", dc_rdata, r.data);
      end
    end
    prev_dcr = dc_ready;
  end

  task automatic ic_req(input logic [31:0] a, input int hold);
    bit got = 0;
    icq.push_back('{chk: 1'b1, data: rd_val(a)});
    @(negedge clk);
    ic_req_valid = 1'b1;
    ic_req_addr  = a;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ic_ready) begin got = 1; break; end
    end
    chk("ic_ready_within_budget", 32'(got), 32'd1);
    repeat (hold) @(negedge clk);
    ic_req_valid = 1'b0;
  endtask

  task automatic dc_req(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int hold);
    bit got = 0;
    dcq.push_back('{chk: !wr, data: rd_val(a)});
    @(negedge clk);
    dc_req_valid = 1'b1;
    dc_req_wr    = wr;
    dc_req_addr  = a;
    dc_wdata     = wd;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dc_ready) begin got = 1; break; end
    end
    chk("dc_ready_within_budget", 32'(got), 32'd1);
    repeat (hold) @(negedge clk);
    dc_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_mem_valid();
    bit got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req_valid) begin got = 1; break; end
    end
    chk("mem_valid_within_budget", 32'(got), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_ic_ready", 32'(ic_ready), 32'd0);
    chk("rst_dc_ready", 32'(dc_ready), 32'd0);
    chk("rst_ic_rdata", ic_rdata, 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    chk("rst_arb_timeout", 32'(arb_timeout), 32'd0);
    rst = 1'b0;

    // 1: I-cache read
    mq.push_back('{addr: 32'h0000_0040, wr: 1'b0, wd: 32'h0});
    ic_req(32'h0000_0040, 0);
    chk("t1_ic_rdata_held", ic_rdata, 32'hDEAD_BEEF);

    // 2: D-cache write, valid held one extra cycle must not re-grant
    mq.push_back('{addr: 32'h0000_0100, wr: 1'b1, wd: 32'h1234_5678});
    dc_req(1'b1, 32'h0000_0100, 32'h1234_5678, 1);
    repeat (4) @(negedge clk);
    chk("t2_no_regrant", 32'(mem_req_valid), 32'd0);

    // 3: simultaneous requests, three rounds each
    do_reset();
`ifdef MEM_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      mq.push_back('{addr: 32'h300 + 32'(4 * i), wr: 1'b0, wd: 32'h0});
      mq.push_back('{addr: 32'h200 + 32'(4 * i), wr: 1'b0, wd: 32'h0});
    end
`else
    for (int i = 0; i < 3; i++) mq.push_back('{addr: 32'h300 + 32'(4 * i), wr: 1'b0, wd: 32'h0});
    for (int i = 0; i < 3; i++) mq.push_back('{addr: 32'h200 + 32'(4 * i), wr: 1'b0, wd: 32'h0});
`endif
    fork
      begin
        for (int i = 0; i < 3; i++) ic_req(32'h200 + 32'(4 * i), 0);
      end
      begin
        for (int i = 0; i < 3; i++) dc_req(1'b0, 32'h300 + 32'(4 * i), 32'h0, 0);
      end
    join
    chk("t3_timeout_clear", 32'(arb_timeout), 32'd0);

    // 4: watchdog fires after 8 stalled grant cycles and stays set
    mem_hold = 1'b1;
    mq.push_back('{addr: 32'h0000_0080, wr: 1'b0, wd: 32'h0});
    fork
      ic_req(32'h0000_0080, 0);
      begin
        wait_mem_valid();
        repeat (7) @(negedge clk);
        chk("t4_timeout_before_limit", 32'(arb_timeout), 32'd0);
        @(negedge clk);
        chk("t4_timeout_at_limit", 32'(arb_timeout), 32'd1);
        repeat (3) @(negedge clk);
        mem_hold = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    chk("t4_timeout_sticky", 32'(arb_timeout), 32'd1);

    // 5: reset while D-cache is granted, then a clean I-cache read
    mq.push_back('{addr: 32'h0000_0500, wr: 1'b1, wd: 32'hCAFE_0001});
    mem_hold = 1'b1;
    @(negedge clk);
    dc_req_valid = 1'b1;
    dc_req_wr    = 1'b1;
    dc_req_addr  = 32'h0000_0500;
    dc_wdata     = 32'hCAFE_0001;
    wait_mem_valid();
    rst          = 1'b1;
    dc_req_valid = 1'b0;
    @(negedge clk);
    chk("t5_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("t5_dc_ready", 32'(dc_ready), 32'd0);
    chk("t5_timeout_cleared", 32'(arb_timeout), 32'd0);
    rst      = 1'b0;
    mem_hold = 1'b0;
    mq.push_back('{addr: 32'h0000_0600, wr: 1'b0, wd: 32'h0});
    ic_req(32'h0000_0600, 0);

    repeat (4) @(negedge clk);
    chk("end_mem_queue_empty", 32'(mq.size()), 32'd0);
    chk("end_ic_queue_empty", 32'(icq.size()), 32'd0);
    chk("end_dc_queue_empty", 32'(dcq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
